iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu_pkg.sv | 13 +
 rtl/iter_alu_core.sv | 24 ++
 rtl/iter_alu.sv | 85 ++++++++
 tb/tb_iter_alu.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/iter_alu_pkg.sv
// definitions: opcode and controller state enums shared by the ALU core and the sequencer.
package definitions;
  typedef enum logic [3:0] {
    kADD   = 4'd0,
    kSUB   = 4'd1,
    kAND   = 4'd2,
    kXOR   = 4'd3,
    kR_XOR = 4'd4,
    kRSH   = 4'd5,
    kMUL   = 4'd6
  } op_mne;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/iter_alu_core.sv
// alu_core: combinational single-cycle operations; undefined opcodes give zero.
module alu_core
  import definitions::*;
#(
  parameter int W = 8
) (
  input  op_mne        op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         c_o
);
  logic [W:0] add, sub;
  always_comb begin
    add = {1'b0, a_i} + {1'b0, b_i};
    sub = {1'b0, a_i} - {1'b0, b_i};
    y_o = op_i == kADD   ? add[W-1:0] :
          op_i == kSUB   ? sub[W-1:0] :
          op_i == kAND   ? a_i & b_i :
          op_i == kXOR   ? a_i ^ b_i :
          op_i == kR_XOR ? {{(W-1){1'b0}}, ^a_i} : '0;
    c_o = op_i == kADD ? add[W] : op_i == kSUB ? sub[W] : 1'b0;
  end
endmodule

// File: rtl/iter_alu.sv
// iter_alu: sequenced ALU; single-cycle ops via alu_core, multi-cycle right shift and shift-add multiply.
module iter_alu
  import definitions::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  op_mne        OP,
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  output logic [W-1:0] Out,
  output logic         Zero,
  output logic         Carry,
  output logic         Busy,
  output logic         Done
);
  state_t          state_q;
  op_mne           op_q;
  logic [CW-1:0]   cnt_q, n_d;
  logic [2*W-1:0]  prod_q, work_d;
  logic [W-1:0]    mcand_q, core_y, single_y;
  logic [W:0]      hi_sum;
  logic [31:0]     b32;
  logic            core_c, single_c, accept;
  alu_core #(.W(W)) u_core (.op_i(OP), .a_i(InputA), .b_i(InputB), .y_o(core_y), .c_o(core_c));
  always_comb begin
    accept   = Start && state_q != RUN;
    b32      = 32'(InputB);
    n_d      = b32 >= 32'(W) ? CW'(W) : InputB[CW-1:0];
    single_y = OP == kRSH ? InputA : core_y;
    single_c = OP == kRSH ? 1'b0 : core_c;
    // Multiply: low half holds the remaining multiplier bits, high half the running sum.
    hi_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    work_d   = op_q == kMUL ? {hi_sum, prod_q[W-1:1]} : prod_q >> 1;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= kADD;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      Out     <= '0;
      Zero    <= 1'b1;
      Carry   <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        op_q    <= OP;
        mcand_q <= InputA;
        if (OP == kMUL || (OP == kRSH && n_d != '0)) begin
          prod_q  <= {{W{1'b0}}, OP == kMUL ? InputB : InputA};
          cnt_q   <= OP == kMUL ? CW'(W) : n_d;
          state_q <= RUN;
          Busy    <= 1'b1;
        end else begin
          Out     <= single_y;
          Zero    <= single_y == '0;
          Carry   <= single_c;
          state_q <= DONE;
          Busy    <= 1'b0;
          Done    <= 1'b1;
        end
      end else if (state_q == RUN) begin
        prod_q <= work_d;
        cnt_q  <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          Out     <= work_d[W-1:0];
          Zero    <= work_d[W-1:0] == '0;
          Carry   <= op_q == kMUL ? |work_d[2*W-1:W] : prod_q[0];
          state_q <= DONE;
          Busy    <= 1'b0;
          Done    <= 1'b1;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed and randomized checks of iter_alu against an arithmetic reference model.
module tb_iter_alu;
  import definitions::*;
  localparam int W = 8;
  logic         Clk = 0, Reset = 1, Start = 0;
  op_mne        OP = kADD;
  logic [W-1:0] InputA = '0, InputB = '0, Out;
  logic         Zero, Carry, Busy, Done;
  logic [W-1:0] last_out = '0;
  int total = 0, bad = 0;

  iter_alu #(.W(W)) dut (.Clk(Clk), .Reset(Reset), .Start(Start), .OP(OP), .InputA(InputA),
    .InputB(InputB), .Out(Out), .Zero(Zero), .Carry(Carry), .Busy(Busy), .Done(Done));

  always #5 Clk = ~Clk;

  function automatic void model(input op_mne op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] y, output logic c, output int lat);
    longint ua = longint'(a), ub = longint'(b), m = longint'(1) << W, r = 0;
    int n;
    lat = 0; c = 0;
    case (op)
      kADD:   begin r = ua + ub; c = r >= m; end
      kSUB:   begin r = (ua - ub + m) % m; c = ua < ub; end
      kAND:   r = ua & ub;
      kXOR:   r = ua ^ ub;
      kR_XOR: r = $countones(a) % 2;
      kRSH:   begin
        n = ub > W ? W : int'(ub);
        r = ua >> n; c = n == 0 ? 1'b0 : 1'(((ua >> (n - 1)) & 1));
        lat = n;
      end
      kMUL:   begin r = ua * ub; c = (r >> W) != 0; lat = W; end
      default: r = 0;
    endcase
    y = W'(r % m);
  endfunction

  task automatic exec(input op_mne op, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [W-1:0] ey; logic ec; int lat;
    model(op, a, b, ey, ec, lat);
    Start = 1; OP = op; InputA = a; InputB = b;
    @(posedge Clk); #1; Start = 0;
    for (int i = 0; i < lat; i++) begin
      total++;
      if (Done !== 1'b0 || Busy !== 1'b1 || Out !== last_out) begin
        bad++;
        $display("FAIL run op=%0d cyc=%0d: Done=%b Busy=%b Out=%h, required Done=0 Busy=1 Out=%h",
                 op, i, Done, Busy, Out, last_out);
      end
      if (noise && i == 2) begin Start = 1; OP = kADD; InputA = 8'h55; InputB = 8'h01; end
      if (noise && i == 3) Start = 0;
      @(posedge Clk); #1;
    end
    total++;
    if (Done !== 1'b1 || Busy !== 1'b0 || Out !== ey || Zero !== (ey == 0) || Carry !== ec) begin
      bad++;
      $display("FAIL result op=%0d a=%h b=%h: Done=%b Busy=%b Out=%h Zero=%b Carry=%b, required Done=1 Busy=0 Out=%h Zero=%b Carry=%b",
               op, a, b, Done, Busy, Out, Zero, Carry, ey, ey == 0, ec);
    end
    last_out = ey;
  endtask

  task automatic check_idle(input string name);
    @(posedge Clk); #1;
    total++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Out !== last_out) begin
      bad++;
      $display("FAIL %s: Done=%b Busy=%b Out=%h, required Done=0 Busy=0 Out=%h", name, Done, Busy, Out, last_out);
    end
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if (Out !== '0 || Zero !== 1'b1 || Carry !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      bad++;
      $display("FAIL %s: Out=%h Zero=%b Carry=%b Busy=%b Done=%b, required 00 1 0 0 0", name, Out, Zero, Carry, Busy, Done);
    end
  endtask

  task automatic test_reset();
    Reset = 1; Start = 1; OP = kADD; InputA = 8'h12; InputB = 8'h34;
    repeat (2) @(posedge Clk);
    #1; check_reset_vals("reset");
    Reset = 0; Start = 0; last_out = '0;
    check_idle("post_reset_idle");
  endtask

  task automatic test_single();
    exec(kADD, 8'hFF, 8'h01, 0); check_idle("add_done_pulse");
    exec(kSUB, 8'h03, 8'h05, 0); check_idle("sub_done_pulse");
    exec(kAND, 8'hF0, 8'h3C, 0);
    exec(kXOR, 8'hF0, 8'h3C, 0);
    exec(kR_XOR, 8'hB5, 8'h00, 0);
    exec(op_mne'(4'hF), 8'hAA, 8'h55, 0); check_idle("undef_done_pulse");
  endtask

  task automatic test_shift();
    exec(kRSH, 8'hB5, 8'd3, 0); check_idle("rsh3_done_pulse");
    exec(kRSH, 8'hB5, 8'd0, 0);
    exec(kRSH, 8'hB5, 8'd20, 0);
    exec(kRSH, 8'h81, 8'd8, 0);
  endtask

  task automatic test_mul();
    exec(kMUL, 8'h10, 8'h11, 1); check_idle("mul_done_pulse");
    exec(kMUL, 8'h0F, 8'h0F, 1);
    exec(kMUL, 8'hFF, 8'hFF, 0);
  endtask

  task automatic test_back_to_back();
    exec(kMUL, 8'h07, 8'h09, 0);
    exec(kXOR, 8'h5A, 8'hFF, 0);
    exec(kRSH, 8'hC3, 8'd2, 0);
    check_idle("b2b_final_idle");
  endtask

  task automatic test_reset_abort();
    Start = 1; OP = kMUL; InputA = 8'h21; InputB = 8'h43;
    @(posedge Clk); #1; Start = 0;
    repeat (3) @(posedge Clk);
    #1; Reset = 1; Start = 1; OP = kADD;
    @(posedge Clk); #1;
    check_reset_vals("abort_reset");
    Reset = 0; Start = 0; last_out = '0;
    for (int i = 0; i < 10; i++) check_idle("abort_no_done");
    exec(kMUL, 8'h21, 8'h43, 0);
  endtask

  task automatic test_random();
    op_mne ops[8] = '{kADD, kSUB, kAND, kXOR, kR_XOR, kRSH, kMUL, op_mne'(4'hC)};
    for (int i = 0; i < 60; i++) begin
      op_mne op = ops[$urandom_range(0, 7)];
      logic [W-1:0] a = W'($urandom), b = W'($urandom);
      if (op == kRSH) b = W'($urandom_range(0, 12));
      exec(op, a, b, 0);
      if ($urandom_range(0, 1) == 1) check_idle("rand_idle");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift();
    test_mul();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
